// File: rtl/mips32_pipeline_if.sv
// Status bundle of the mips32_pipeline core.
// The core (master) drives the halt flag and the two hazard indicators;
// the surrounding system or a testbench (slave) observes them.
interface mips32_pipeline_if;
   logic halted;
   logic stall;
   logic takenBranch;

   modport master (output halted, output stall, output takenBranch);
   modport slave  (input  halted, input  stall, input  takenBranch);
endinterface

// File: rtl/mips32_pipeline.sv
// mips32_pipeline: five-stage (IF, ID, EX, MEM, WB) in-order 32-bit MIPS-style core.
// Unified word-addressed Mem, 32x32 register file, hazards resolved in hardware.
// Build option: define FORWARDING_EN for EX/MEM and MEM/WB operand forwarding
// (load-use costs one stall); without it, ID interlocks on any in-flight producer.
module mips32_pipeline #(
   parameter int MEM_DEPTH = 1024
) (
   input  logic clk,
   input  logic rst_n,
   mips32_pipeline_if.master status
);

   localparam int AW = $clog2(MEM_DEPTH);

   localparam logic [5:0] ADD   = 6'b000000;
   localparam logic [5:0] SUB   = 6'b000001;
   localparam logic [5:0] AND   = 6'b000010;
   localparam logic [5:0] OR    = 6'b000011;
   localparam logic [5:0] SLT   = 6'b000100;
   localparam logic [5:0] MUL   = 6'b000101;
   localparam logic [5:0] LW    = 6'b001000;
   localparam logic [5:0] SW    = 6'b001001;
   localparam logic [5:0] ADDI  = 6'b001010;
   localparam logic [5:0] SUBI  = 6'b001011;
   localparam logic [5:0] SLTI  = 6'b001100;
   localparam logic [5:0] BNEQZ = 6'b001101;
   localparam logic [5:0] BEQZ  = 6'b001110;
   localparam logic [5:0] HLT   = 6'b111111;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
   } ifIdT;

   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic        wrEn;
      logic        isLoad;
      logic        isStore;
      logic        isBranch;
      logic        isHalt;
      logic [31:0] rsVal;
      logic [31:0] rtVal;
      logic [31:0] imm;
      logic [31:0] pc;
   } idExT;

   typedef struct packed {
      logic        valid;
      logic        wrEn;
      logic        isLoad;
      logic        isStore;
      logic        isHalt;
      logic [4:0]  dest;
      logic [31:0] aluOut;
      logic [31:0] storeData;
   } exMemT;

   typedef struct packed {
      logic        valid;
      logic        wrEn;
      logic        isHalt;
      logic [4:0]  dest;
      logic [31:0] result;
   } memWbT;

   logic [31:0] regs [0:31];
   logic [31:0] Mem  [0:MEM_DEPTH-1];
   logic [31:0] PC;
   logic        halted;
   logic        taken_branch;
   logic        stall;

   ifIdT  ifId_q,  ifId_d;
   idExT  idEx_q,  idEx_d;
   exMemT exMem_q, exMem_d;
   memWbT memWb_q, memWb_d;
   logic [31:0] pc_d;
   logic        halted_d;

   logic [5:0]  idOp;
   logic [4:0]  idRs, idRt, idRd, idDest;
   logic [31:0] idImm, idRsVal, idRtVal;
   logic        idUsesRs, idUsesRt, idWrEn, idIsLoad, idIsStore, idIsBranch, idIsHalt;
   logic        hazard, haltActive, wbWrEn;
   logic [31:0] exA, exB, exAlu, branchTarget;

   assign wbWrEn = memWb_q.valid && memWb_q.wrEn && (memWb_q.dest != 5'd0) && !halted;

   // Decode the instruction sitting in ID: fields, sources used and destination written
   always_comb begin
      idOp       = ifId_q.instr[31:26];
      idRs       = ifId_q.instr[25:21];
      idRt       = ifId_q.instr[20:16];
      idRd       = ifId_q.instr[15:11];
      idImm      = {{16{ifId_q.instr[15]}}, ifId_q.instr[15:0]};
      idUsesRs   = 1'b0;
      idUsesRt   = 1'b0;
      idWrEn     = 1'b0;
      idIsLoad   = 1'b0;
      idIsStore  = 1'b0;
      idIsBranch = 1'b0;
      idIsHalt   = 1'b0;
      idDest     = 5'd0;
      case (idOp)
         ADD, SUB, AND, OR, SLT, MUL: begin
            idUsesRs = 1'b1;
            idUsesRt = 1'b1;
            idWrEn   = 1'b1;
            idDest   = idRd;
         end
         ADDI, SUBI, SLTI: begin
            idUsesRs = 1'b1;
            idWrEn   = 1'b1;
            idDest   = idRt;
         end
         LW: begin
            idUsesRs = 1'b1;
            idWrEn   = 1'b1;
            idIsLoad = 1'b1;
            idDest   = idRt;
         end
         SW: begin
            idUsesRs  = 1'b1;
            idUsesRt  = 1'b1;
            idIsStore = 1'b1;
         end
         BEQZ, BNEQZ: begin
            idUsesRs   = 1'b1;
            idIsBranch = 1'b1;
         end
         HLT: idIsHalt = 1'b1;
         default: ;
      endcase
   end

   // Register file read with write-through from the write-back port; r0 always reads zero
   always_comb begin
      idRsVal = regs[idRs];
      idRtVal = regs[idRt];
      if (wbWrEn && memWb_q.dest == idRs) idRsVal = memWb_q.result;
      if (wbWrEn && memWb_q.dest == idRt) idRtVal = memWb_q.result;
      if (idRs == 5'd0) idRsVal = '0;
      if (idRt == 5'd0) idRtVal = '0;
   end

   // Interlock detection: with forwarding only a load directly ahead blocks ID,
   // otherwise any valid producer still in EX or MEM blocks it
   always_comb begin
      hazard = 1'b0;
`ifdef FORWARDING_EN
      if (idEx_q.valid && idEx_q.isLoad && idEx_q.dest != 5'd0 &&
          ((idUsesRs && idRs == idEx_q.dest) || (idUsesRt && idRt == idEx_q.dest)))
         hazard = 1'b1;
`else
      if (idEx_q.valid && idEx_q.wrEn && idEx_q.dest != 5'd0 &&
          ((idUsesRs && idRs == idEx_q.dest) || (idUsesRt && idRt == idEx_q.dest)))
         hazard = 1'b1;
      if (exMem_q.valid && exMem_q.wrEn && exMem_q.dest != 5'd0 &&
          ((idUsesRs && idRs == exMem_q.dest) || (idUsesRt && idRt == exMem_q.dest)))
         hazard = 1'b1;
`endif
      if (!ifId_q.valid) hazard = 1'b0;
   end

   // EX operand selection; the EX/MEM producer is younger and overrides MEM/WB
   always_comb begin
      exA = idEx_q.rsVal;
      exB = idEx_q.rtVal;
`ifdef FORWARDING_EN
      if (memWb_q.valid && memWb_q.wrEn && memWb_q.dest != 5'd0) begin
         if (memWb_q.dest == idEx_q.rs) exA = memWb_q.result;
         if (memWb_q.dest == idEx_q.rt) exB = memWb_q.result;
      end
      if (exMem_q.valid && exMem_q.wrEn && !exMem_q.isLoad && exMem_q.dest != 5'd0) begin
         if (exMem_q.dest == idEx_q.rs) exA = exMem_q.aluOut;
         if (exMem_q.dest == idEx_q.rt) exB = exMem_q.aluOut;
      end
`endif
   end

   // ALU, branch condition and branch target computed in EX
   always_comb begin
      exAlu = '0;
      case (idEx_q.op)
         ADD:         exAlu = exA + exB;
         SUB:         exAlu = exA - exB;
         AND:         exAlu = exA & exB;
         OR:          exAlu = exA | exB;
         SLT:         exAlu = {31'b0, $signed(exA) < $signed(exB)};
         MUL:         exAlu = exA * exB;
         ADDI, LW, SW: exAlu = exA + idEx_q.imm;
         SUBI:        exAlu = exA - idEx_q.imm;
         SLTI:        exAlu = {31'b0, $signed(exA) < $signed(idEx_q.imm)};
         default:     ;
      endcase
      taken_branch = 1'b0;
      if (idEx_q.valid && idEx_q.isBranch)
         taken_branch = (idEx_q.op == BEQZ) ? (exA == 32'd0) : (exA != 32'd0);
      branchTarget = idEx_q.pc + 32'd1 + idEx_q.imm;
   end

   // Fetch stops while an HLT is anywhere from ID onward or the core has halted
   always_comb begin
      stall      = hazard && !taken_branch;
      haltActive = (ifId_q.valid && idIsHalt) || (idEx_q.valid && idEx_q.isHalt) ||
                   (exMem_q.valid && exMem_q.isHalt) || (memWb_q.valid && memWb_q.isHalt) ||
                   halted;
   end

   // Next-state of PC and every pipeline register; a taken branch outranks a stall
   always_comb begin
      pc_d     = PC;
      ifId_d   = ifId_q;
      idEx_d   = '0;
      exMem_d  = '0;
      memWb_d  = '0;
      halted_d = halted || (memWb_q.valid && memWb_q.isHalt);

      if (taken_branch) begin
         pc_d   = branchTarget;
         ifId_d = '0;
      end else if (stall) begin
         pc_d   = PC;
      end else if (haltActive) begin
         ifId_d = '0;
      end else begin
         pc_d         = PC + 32'd1;
         ifId_d.valid = 1'b1;
         ifId_d.instr = Mem[PC[AW-1:0]];
         ifId_d.pc    = PC;
      end

      if (!taken_branch && !stall && ifId_q.valid) begin
         idEx_d.valid    = 1'b1;
         idEx_d.op       = idOp;
         idEx_d.rs       = idRs;
         idEx_d.rt       = idRt;
         idEx_d.dest     = idDest;
         idEx_d.wrEn     = idWrEn;
         idEx_d.isLoad   = idIsLoad;
         idEx_d.isStore  = idIsStore;
         idEx_d.isBranch = idIsBranch;
         idEx_d.isHalt   = idIsHalt;
         idEx_d.rsVal    = idRsVal;
         idEx_d.rtVal    = idRtVal;
         idEx_d.imm      = idImm;
         idEx_d.pc       = ifId_q.pc;
      end

      exMem_d.valid     = idEx_q.valid;
      exMem_d.wrEn      = idEx_q.wrEn;
      exMem_d.isLoad    = idEx_q.isLoad;
      exMem_d.isStore   = idEx_q.isStore;
      exMem_d.isHalt    = idEx_q.isHalt;
      exMem_d.dest      = idEx_q.dest;
      exMem_d.aluOut    = exAlu;
      exMem_d.storeData = exB;

      memWb_d.valid  = exMem_q.valid;
      memWb_d.wrEn   = exMem_q.wrEn;
      memWb_d.isHalt = exMem_q.isHalt;
      memWb_d.dest   = exMem_q.dest;
      memWb_d.result = exMem_q.isLoad ? Mem[exMem_q.aluOut[AW-1:0]] : exMem_q.aluOut;
   end

   // Pipeline state registers; reset empties the pipe and restarts fetch at address 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PC      <= '0;
         halted  <= 1'b0;
         ifId_q  <= '0;
         idEx_q  <= '0;
         exMem_q <= '0;
         memWb_q <= '0;
      end else begin
         PC      <= pc_d;
         halted  <= halted_d;
         ifId_q  <= ifId_d;
         idEx_q  <= idEx_d;
         exMem_q <= exMem_d;
         memWb_q <= memWb_d;
      end
   end

   // Register file write-back; cleared on reset, r0 is never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wbWrEn) begin
         regs[memWb_q.dest] <= memWb_q.result;
      end
   end

   // Store port of the unified memory; contents survive reset
   always_ff @(posedge clk) begin
      if (exMem_q.valid && exMem_q.isStore && !halted)
         Mem[exMem_q.aluOut[AW-1:0]] <= exMem_q.storeData;
   end

   assign status.halted      = halted;
   assign status.stall       = stall;
   assign status.takenBranch = taken_branch;

endmodule

// File: tb/tb_mips32_pipeline.sv
// Testbench for mips32_pipeline: directed programs plus random programs, all
// compared against an instruction-at-a-time reference interpreter.
module tb_mips32_pipeline;

   localparam int MEM_DEPTH = 1024;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;
   localparam logic [5:0] OP_NOP   = 6'b010000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mips32_pipeline_if statusIf ();

   mips32_pipeline #(.MEM_DEPTH(MEM_DEPTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .status (statusIf)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;

   logic [31:0] image     [0:MEM_DEPTH-1];
   logic [31:0] modelRegs [0:31];
   logic [31:0] modelMem  [0:MEM_DEPTH-1];
   int          modelTaken;
   int          modelHltPc;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] encR(input logic [5:0] op, input int rs, input int rt, input int rd);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
   endfunction

   function automatic logic [31:0] encI(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic clearImage();
      for (int i = 0; i < MEM_DEPTH; i++) image[i] = '0;
   endtask

   task automatic loadImage();
      for (int i = 0; i < MEM_DEPTH; i++) dut.Mem[i] = image[i];
   endtask

   // Sequential ISA interpreter: one instruction per step, no notion of pipeline
   task automatic runModel();
      int pc;
      int simm;
      int rs, rt, rd;
      logic [31:0] ins, a, b, imm, addr;
      logic [5:0] op;
      logic done;
      for (int i = 0; i < 32; i++) modelRegs[i] = '0;
      for (int i = 0; i < MEM_DEPTH; i++) modelMem[i] = image[i];
      modelTaken = 0;
      modelHltPc = -1;
      pc = 0;
      done = 1'b0;
      for (int step = 0; step < 10000 && !done; step++) begin
         ins  = modelMem[pc % MEM_DEPTH];
         op   = ins[31:26];
         rs   = int'(ins[25:21]);
         rt   = int'(ins[20:16]);
         rd   = int'(ins[15:11]);
         a    = modelRegs[rs];
         b    = modelRegs[rt];
         simm = $signed(ins[15:0]);
         imm  = 32'(simm);
         addr = a + imm;
         pc   = pc + 1;
         case (op)
            OP_ADD:   modelRegs[rd] = a + b;
            OP_SUB:   modelRegs[rd] = a - b;
            OP_AND:   modelRegs[rd] = a & b;
            OP_OR:    modelRegs[rd] = a | b;
            OP_SLT:   modelRegs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MUL:   modelRegs[rd] = a * b;
            OP_ADDI:  modelRegs[rt] = a + imm;
            OP_SUBI:  modelRegs[rt] = a - imm;
            OP_SLTI:  modelRegs[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_LW:    modelRegs[rt] = modelMem[addr % MEM_DEPTH];
            OP_SW:    modelMem[addr % MEM_DEPTH] = b;
            OP_BEQZ:  if (a == 32'd0) begin pc = pc + simm; modelTaken++; end
            OP_BNEQZ: if (a != 32'd0) begin pc = pc + simm; modelTaken++; end
            OP_HLT:   begin done = 1'b1; modelHltPc = pc; end
            default:  ;
         endcase
         modelRegs[0] = '0;
      end
   endtask

   // Releases reset and runs until halted or the cycle budget expires
   task automatic runUntilHalt(input string tag, input int maxCycles,
                               output int stallCycles, output int takenPulses, output int r6Is99);
      int n;
      n = 0;
      stallCycles = 0;
      takenPulses = 0;
      r6Is99 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      while (!statusIf.halted && n < maxCycles) begin
         @(negedge clk);
         n++;
         if (statusIf.stall) stallCycles++;
         if (statusIf.takenBranch) takenPulses++;
         if (dut.regs[6] == 32'd99) r6Is99++;
      end
      checkOutput({tag, " halted"}, 32'(statusIf.halted), 32'd1);
   endtask

   task automatic enterReset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " PC"}, dut.PC, 32'd0);
      checkOutput({tag, " halted"}, 32'(statusIf.halted), 32'd0);
      checkOutput({tag, " stall"}, 32'(statusIf.stall), 32'd0);
      checkOutput({tag, " taken_branch"}, 32'(statusIf.takenBranch), 32'd0);
   endtask

   task automatic compareRegs(input string tag, input int upTo);
      for (int r = 0; r < upTo; r++)
         checkOutput($sformatf("%s r%0d", tag, r), dut.regs[r], modelRegs[r]);
   endtask

   // Dependency-chain program from the test plan, r1 set up by the first instruction
   task automatic buildDepChain(input logic [31:0] loadValue);
      clearImage();
      image[0] = encI(OP_ADDI, 0, 1, 16'd10);
      image[1] = encI(OP_ADDI, 1, 2, 16'd5);
      image[2] = encR(OP_SUB, 2, 1, 3);
      image[3] = encI(OP_LW, 2, 4, 16'd0);
      image[4] = encR(OP_ADD, 4, 3, 5);
      image[5] = encI(OP_BEQZ, 5, 0, 16'd1);
      image[6] = encI(OP_ADDI, 0, 6, 16'd99);
      image[7] = encI(OP_ADDI, 0, 6, 16'd42);
      image[8] = encI(OP_HLT, 0, 0, 16'd0);
      image[15] = loadValue;
   endtask

   // Random program: seeded registers, a base pointer in r7, random body, HLT, poison
   task automatic applyStimulus(input int nInstr);
      int hltIdx, k, maxOff;
      clearImage();
      for (int d = 0; d < 16; d++) image[200 + d] = $urandom;
      for (int r = 1; r <= 6; r++) image[r - 1] = encI(OP_ADDI, 0, r, 16'($urandom_range(0, 65535)));
      image[6] = encI(OP_ADDI, 0, 7, 16'd200);
      hltIdx = 7 + nInstr;
      for (int i = 7; i < hltIdx; i++) begin
         k = int'($urandom_range(0, 13));
         case (k)
            0, 1, 2, 3, 4, 5:
               image[i] = encR(6'(k), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                               int'($urandom_range(1, 6)));
            6, 7, 8:
               image[i] = encI((k == 6) ? OP_ADDI : (k == 7) ? OP_SUBI : OP_SLTI,
                               int'($urandom_range(0, 7)), int'($urandom_range(1, 6)),
                               16'($urandom_range(0, 65535)));
            9:  image[i] = encI(OP_LW, 7, int'($urandom_range(1, 6)), 16'($urandom_range(0, 15)));
            10: image[i] = encI(OP_SW, 7, int'($urandom_range(0, 7)), 16'($urandom_range(0, 15)));
            11, 12: begin
               maxOff = hltIdx - 1 - i;
               if (maxOff > 3) maxOff = 3;
               image[i] = encI((k == 11) ? OP_BEQZ : OP_BNEQZ, int'($urandom_range(0, 7)), 0,
                               16'($urandom_range(0, maxOff)));
            end
            default: image[i] = {OP_NOP, 26'd0};
         endcase
      end
      image[hltIdx]     = encI(OP_HLT, 0, 0, 16'd0);
      image[hltIdx + 1] = encI(OP_ADDI, 0, 1, 16'h0777);
      image[hltIdx + 2] = encI(OP_ADDI, 0, 2, 16'h0777);
   endtask

   // Main sequence of directed and random programs
   initial begin
      int st, tk, r6hits;
      int expStalls;
      logic [31:0] lwValue;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkReset("por");

      buildDepChain(32'd0);
      loadImage();
      runModel();
      runUntilHalt("depA", 500, st, tk, r6hits);
      compareRegs("depA", 8);
      checkOutput("depA r2", dut.regs[2], 32'd15);
      checkOutput("depA r3", dut.regs[3], 32'd5);
      checkOutput("depA r4", dut.regs[4], 32'd0);
      checkOutput("depA r5", dut.regs[5], 32'd5);
      checkOutput("depA r6", dut.regs[6], 32'd42);
      checkOutput("depA taken count", 32'(tk), 32'(modelTaken));
      checkOutput("depA r6 saw 99", 32'(r6hits > 0), 32'd1);

      enterReset();
      buildDepChain(32'hFFFF_FFFB);
      loadImage();
      runModel();
      runUntilHalt("depB", 500, st, tk, r6hits);
      compareRegs("depB", 8);
      checkOutput("depB r4", dut.regs[4], 32'hFFFF_FFFB);
      checkOutput("depB r5", dut.regs[5], 32'd0);
      checkOutput("depB r6", dut.regs[6], 32'd42);
      checkOutput("depB taken count", 32'(tk), 32'd1);
      checkOutput("depB r6 saw 99", 32'(r6hits), 32'd0);

      enterReset();
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkReset("midrun");
      repeat (2) @(negedge clk);
      runUntilHalt("restart", 500, st, tk, r6hits);
      compareRegs("restart", 8);
      checkOutput("restart taken count", 32'(tk), 32'd1);

      enterReset();
      clearImage();
      image[0] = encI(OP_BEQZ, 0, 0, 16'd1);
      image[1] = encI(OP_HLT, 0, 0, 16'd0);
      image[2] = encI(OP_ADDI, 0, 3, 16'd1234);
      image[3] = encI(OP_SW, 0, 3, 16'd20);
      image[4] = encI(OP_LW, 0, 7, 16'd20);
      image[5] = encI(OP_ADDI, 0, 0, 16'd77);
      image[6] = encR(OP_ADD, 7, 0, 8);
      image[7] = encI(OP_HLT, 0, 0, 16'd0);
      image[8] = encI(OP_ADDI, 0, 9, 16'd5);
      loadImage();
      runModel();
      runUntilHalt("swlw", 500, st, tk, r6hits);
      compareRegs("swlw", 10);
      checkOutput("swlw r7", dut.regs[7], 32'd1234);
      checkOutput("swlw r0", dut.regs[0], 32'd0);
      checkOutput("swlw r9", dut.regs[9], 32'd0);
      checkOutput("swlw Mem20", dut.Mem[20], 32'd1234);
      checkOutput("swlw taken count", 32'(tk), 32'd1);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checkOutput($sformatf("hlt PC c%0d", c), dut.PC, 32'(modelHltPc));
         checkOutput($sformatf("hlt halted c%0d", c), 32'(statusIf.halted), 32'd1);
      end
      checkOutput("hlt r9 after", dut.regs[9], 32'd0);

      enterReset();
      clearImage();
      lwValue = $urandom;
      image[0] = encI(OP_LW, 0, 4, 16'd50);
      image[1] = encR(OP_ADD, 4, 4, 5);
      image[2] = encI(OP_HLT, 0, 0, 16'd0);
      image[50] = lwValue;
      loadImage();
      runModel();
      runUntilHalt("loaduse", 500, st, tk, r6hits);
`ifdef FORWARDING_EN
      expStalls = 1;
`else
      expStalls = 2;
`endif
      checkOutput("loaduse stalls", 32'(st), 32'(expStalls));
      checkOutput("loaduse r5", dut.regs[5], lwValue + lwValue);
      checkOutput("loaduse r4", dut.regs[4], modelRegs[4]);

      for (int p = 0; p < 8; p++) begin
         enterReset();
         applyStimulus(30);
         loadImage();
         runModel();
         runUntilHalt($sformatf("rand%0d", p), 2000, st, tk, r6hits);
         compareRegs($sformatf("rand%0d", p), 8);
         for (int d = 200; d < 216; d++)
            checkOutput($sformatf("rand%0d Mem%0d", p, d), dut.Mem[d], modelMem[d]);
         checkOutput($sformatf("rand%0d taken count", p), 32'(tk), 32'(modelTaken));
         checkOutput($sformatf("rand%0d PC", p), dut.PC, 32'(modelHltPc));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
